dmem_responder: RTL and testbench

Data-memory responder for the single-cycle MIPS core: the target end of the core's `memwrite`/`aluout`/`writedata`/`readdata` data port. It holds a word-addressed RAM for the low half of the address space and a small MMIO register block for the high half. The MMIO block contains GPIO, a free-running timer with compare/interrupt, and a sticky misaligned-store error flag. Reads are combinational so the single-cycle core needs no stall; all state changes occur on the rising clock edge.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_timer.sv | 31 +++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared decode constants and types for the data-memory responder.
package dmem_pkg;

  localparam int unsigned REGION_BIT = 31;

  localparam logic [2:0] OFF_GPIO_OUT  = 3'd0;
  localparam logic [2:0] OFF_GPIO_IN   = 3'd1;
  localparam logic [2:0] OFF_TIMER     = 3'd2;
  localparam logic [2:0] OFF_TIMER_CMP = 3'd3;
  localparam logic [2:0] OFF_STATUS    = 3'd4;

  localparam int unsigned ST_MATCH    = 0;
  localparam int unsigned ST_MISALIGN = 1;

  typedef enum logic [2:0] {
    TgtRam,
    TgtGpioOut,
    TgtGpioIn,
    TgtTimer,
    TgtTimerCmp,
    TgtStatus,
    TgtUnmapped
  } target_e;

  function automatic target_e decode_target(input logic [31:0] addr);
    if (!addr[REGION_BIT]) return TgtRam;
    case (addr[4:2])
      OFF_GPIO_OUT:  return TgtGpioOut;
      OFF_GPIO_IN:   return TgtGpioIn;
      OFF_TIMER:     return TgtTimer;
      OFF_TIMER_CMP: return TgtTimerCmp;
      OFF_STATUS:    return TgtStatus;
      default:       return TgtUnmapped;
    endcase
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running 32-bit timer with compare register; only built under DMEM_MMIO_TIMER_EN.
module dmem_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_clr,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        match
);

  logic [31:0] count_q;
  logic [31:0] cmp_q;

  // A clear in the same cycle as the increment wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      cmp_q   <= '0;
    end else begin
      count_q <= count_clr ? '0 : count_q + 32'd1;
      if (cmp_we) cmp_q <= cmp_wdata;
    end
  end

  assign count = count_q;
  assign cmp   = cmp_q;
  assign match = (count_q == cmp_q) && (cmp_q != '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the single-cycle core: RAM below 0x8000_0000, MMIO above.
// Optional timer/compare/interrupt is built only when DMEM_MMIO_TIMER_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned GPIO_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq,
  output logic              misalign_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  target_e            tgt;
  logic               aligned;
  logic               wr_ok;
  logic               misalign_set;
  logic [IDX_W-1:0]   ram_idx;
  logic [31:0]        mem [DEPTH];
  logic [GPIO_W-1:0]  gpio_out_q;
  logic [GPIO_W-1:0]  sync1_q;
  logic [GPIO_W-1:0]  sync2_q;
  logic [1:0]         status_q;
  logic [1:0]         status_d;
  logic               match_evt;
  logic               unused_addr;

  assign tgt          = decode_target(addr);
  assign aligned      = (addr[1:0] == 2'b00);
  assign wr_ok        = memwrite && aligned;
  assign misalign_set = memwrite && !aligned;
  assign ram_idx      = addr[IDX_W+1:2];
  assign unused_addr  = ^addr;

  // RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && (tgt == TgtRam)) mem[ram_idx] <= writedata;
  end

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] timer_count;
  logic [31:0] timer_cmp;

  dmem_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .count_clr (wr_ok && (tgt == TgtTimer)),
    .cmp_we    (wr_ok && (tgt == TgtTimerCmp)),
    .cmp_wdata (writedata),
    .count     (timer_count),
    .cmp       (timer_cmp),
    .match     (match_evt)
  );
`else
  assign match_evt = 1'b0;
`endif

  // New set events override a simultaneous write-1-to-clear.
  always_comb begin
    status_d = status_q;
    if (wr_ok && (tgt == TgtStatus)) status_d = status_q & ~writedata[1:0];
    if (match_evt)    status_d[ST_MATCH]    = 1'b1;
    if (misalign_set) status_d[ST_MISALIGN] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      status_q   <= '0;
    end else begin
      if (wr_ok && (tgt == TgtGpioOut)) gpio_out_q <= writedata[GPIO_W-1:0];
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      status_q <= status_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (tgt)
      TgtRam:      readdata = mem[ram_idx];
      TgtGpioOut:  readdata[GPIO_W-1:0] = gpio_out_q;
      TgtGpioIn:   readdata[GPIO_W-1:0] = sync2_q;
`ifdef DMEM_MMIO_TIMER_EN
      TgtTimer:    readdata = timer_count;
      TgtTimerCmp: readdata = timer_cmp;
`endif
      TgtStatus:   readdata[1:0] = status_q;
      default:     readdata = '0;
    endcase
  end

  assign gpio_out     = gpio_out_q;
  assign irq          = status_q[ST_MATCH];
  assign misalign_err = status_q[ST_MISALIGN];

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, randomized model run, directed corners.
module tb_dmem_responder;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned GPIO_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              memwrite = 1'b0;
  logic [31:0]       addr = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [GPIO_W-1:0] gpio_out;
  logic              irq;
  logic              misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH  (DEPTH),
    .GPIO_W (GPIO_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .addr         (addr),
    .writedata    (writedata),
    .readdata     (readdata),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .irq          (irq),
    .misalign_err (misalign_err)
  );

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    bit          mis;
    string       name;
  } vec_t;

  vec_t tbl [12];

  // Reference state: RAM words, GPIO output, misalign flag, gpio_in delay line.
  logic [31:0]       ram_m [DEPTH];
  logic [GPIO_W-1:0] gout_m;
  logic              mis_m;
  logic [GPIO_W-1:0] g1;
  logic [GPIO_W-1:0] g2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    cyc();
    memwrite  = 1'b0;
  endtask

  task automatic load(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, readdata, exp);
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  initial begin
    // Reset
    reset = 1'b0;
    repeat (3) cyc();
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'h0);
    reset = 1'b1;
    cyc();

    // Preload every RAM word so later reads are defined.
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram_m[i] = $urandom;
      store(32'(i * 4), ram_m[i]);
    end

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, "st_10"};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, "ld_10"};
    tbl[2]  = '{1'b0, 32'h0000_0110, 32'h0,         32'hDEAD_BEEF, 1'b0, "ld_alias"};
    tbl[3]  = '{1'b0, 32'h7FFF_FF13, 32'h0,         32'hDEAD_BEEF, 1'b0, "ld_misal"};
    tbl[4]  = '{1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0,         1'b1, "st_misal"};
    tbl[5]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, "ld_after_misal"};
    tbl[6]  = '{1'b1, 32'h8000_0010, 32'h0000_0002, 32'h0,         1'b0, "w1c_misal"};
    tbl[7]  = '{1'b1, 32'h8000_0000, 32'hFFFF_00A5, 32'h0,         1'b0, "st_gpio"};
    tbl[8]  = '{1'b0, 32'h8000_0020, 32'h0,         32'h0000_00A5, 1'b0, "ld_gpio_alias"};
    tbl[9]  = '{1'b0, 32'h8000_0014, 32'h0,         32'h0,         1'b0, "ld_off5"};
    tbl[10] = '{1'b1, 32'h8000_0004, 32'h0000_FFFF, 32'h0,         1'b0, "st_gpio_in"};
    tbl[11] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0000_00A5, 1'b0, "ld_gpio"};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) begin
        store(tbl[i].a, tbl[i].d);
      end else begin
        load(tbl[i].name, tbl[i].a, tbl[i].exp);
        cyc();
      end
      check({tbl[i].name, "_mis"}, 32'(misalign_err), 32'(tbl[i].mis));
    end
    check("gpio_out_pin", 32'(gpio_out), 32'h0000_00A5);
    load("ld_off7", 32'h8000_001C, 32'h0);
    cyc();

    ram_m[4] = 32'hDEAD_BEEF;
    gout_m   = 16'h00A5;
    mis_m    = 1'b0;
    g1       = '0;
    g2       = '0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      int unsigned op;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
      bit          wr;
      op  = $urandom_range(0, 7);
      a   = $urandom;
      d   = $urandom;
      exp = '0;
      wr  = 1'b0;
      gpio_in = GPIO_W'($urandom);
      case (op)
        0: begin a = {1'b0, a[30:2], 2'b00}; wr = 1'b1; end
        1: begin a = {1'b0, a[30:0]}; exp = ram_m[widx(a)]; end
        2: begin a[1:0] = 2'($urandom_range(1, 3)); wr = 1'b1; end
        3: begin a = {1'b1, a[30:5], 5'h00}; wr = 1'b1; end
        4: begin a = {1'b1, a[30:5], 5'h00} | 32'(a[1:0]); exp = 32'(gout_m); end
        5: begin a = {1'b1, a[30:5], 5'h04}; exp = 32'(g2); end
        6: begin a = {1'b1, a[30:5], 5'h10}; wr = 1'b1; end
        default: begin a = {1'b1, a[30:5], 5'h10}; exp = {30'h0, mis_m, 1'b0}; end
      endcase
      memwrite  = wr;
      addr      = a;
      writedata = d;
      #1;
      if (!wr) check("rand_load", readdata, exp);
      cyc();
      memwrite = 1'b0;
      case (op)
        0: ram_m[widx(a)] = d;
        2: mis_m = 1'b1;
        3: gout_m = d[GPIO_W-1:0];
        6: mis_m = mis_m & ~d[1];
        default: ;
      endcase
      g2 = g1;
      g1 = gpio_in;
      check("rand_gpio_out", 32'(gpio_out), 32'(gout_m));
      check("rand_misalign", 32'(misalign_err), 32'(mis_m));
      check("rand_irq", 32'(irq), 32'h0);
    end

    // Synchronizer latency: two edges before the new value reads back.
    gpio_in = '0;
    repeat (3) cyc();
    gpio_in = 16'h003C;
    load("gpio_in_c0", 32'h8000_0004, 32'h0);
    cyc();
    load("gpio_in_c1", 32'h8000_0004, 32'h0);
    cyc();
    load("gpio_in_c2", 32'h8000_0004, 32'h0000_003C);
    cyc();

    // Asynchronous reset mid-run.
    store(32'h8000_0000, 32'h0000_1234);
    store(32'h0000_0001, 32'h0);
    check("pre_rst_misal", 32'(misalign_err), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_gpio_out", 32'(gpio_out), 32'h0);
    check("mid_rst_misal", 32'(misalign_err), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    load("mid_rst_status", 32'h8000_0010, 32'h0);
    load("mid_rst_timer", 32'h8000_0008, 32'h0);
    load("mid_rst_ram", 32'h0000_0010, ram_m[4]);
    cyc();
    cyc();
    reset = 1'b1;
    load("rel_timer0", 32'h8000_0008, 32'h0);
    cyc();

`ifdef DMEM_MMIO_TIMER_EN
    load("rel_timer1", 32'h8000_0008, 32'h1);
    cyc();
    load("rel_timer2", 32'h8000_0008, 32'h2);
    store(32'h8000_000C, 32'd10);
    load("cmp_rd", 32'h8000_000C, 32'd10);
    store(32'h8000_0008, 32'h0000_FFFF);
    load("tmr_clr", 32'h8000_0008, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      check("irq_early", 32'(irq), 32'h0);
      cyc();
    end
    load("tmr_match", 32'h8000_0008, 32'd10);
    check("irq_pre_edge", 32'(irq), 32'h0);
    cyc();
    check("irq_rise", 32'(irq), 32'h1);
    store(32'h8000_0008, 32'h0);
    repeat (10) cyc();
    load("tmr_match2", 32'h8000_0008, 32'd10);
    store(32'h8000_0010, 32'h1);
    check("irq_set_wins", 32'(irq), 32'h1);
    store(32'h8000_0010, 32'h1);
    check("irq_w1c", 32'(irq), 32'h0);
`else
    store(32'h8000_0008, 32'hFFFF_FFFF);
    load("off2_zero", 32'h8000_0008, 32'h0);
    store(32'h8000_000C, 32'h0000_0003);
    load("off3_zero", 32'h8000_000C, 32'h0);
    for (int k = 0; k < 20; k++) begin
      check("irq_tied", 32'(irq), 32'h0);
      cyc();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
